// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- handshaked sequential ALU.
//   Single-cycle ops (add/sub/cmp/logic/shift/rotate) complete one cycle after
//   accept; unsigned multiply runs a WIDTH-cycle shift-add engine.
//   Result and N/Z/V/C flags are registered and held while out_valid is high.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake (in_ready depends on state only)
//   optcode, a, b, shift     operation and operands, sampled on accept
//   out_valid / out_ready    output handshake
//   result                   registered result
//   negative/zero/overflow/carry  registered flags
//   illegal                  completed op had an undefined optcode
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       optcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t state;

    // Multiplier state: accumulator, left-shifting multiplicand, right-shifting multiplier.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc_nxt;

    // Single-cycle datapath, evaluated on the operands being accepted.
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] s_res;
    logic [WIDTH-1:0] tmp;
    logic             s_v;
    logic             s_c;
    logic             s_ill;
    logic [SHW-1:0]   sm1;
    logic [SHW:0]     wms;

    assign a_s     = a;
    assign sm1     = shift - SHW'(1);
    // WIDTH - shift; equals WIDTH when shift is 0, which makes the wrap term vanish.
    assign wms     = (SHW+1)'(WIDTH) - {1'b0, shift};
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    always_comb begin
        s_res = '0;
        s_v   = 1'b0;
        s_c   = 1'b0;
        s_ill = 1'b0;
        tmp   = '0;
        case (optcode)
            4'b0000: begin
                {s_c, s_res} = {1'b0, a} + {1'b0, b};
                s_v = (a[MSB] == b[MSB]) && (s_res[MSB] != a[MSB]);
            end
            4'b0001, 4'b1001: begin
                s_res = a - b;
                s_c   = (a >= b);
                s_v   = (a[MSB] != b[MSB]) && (s_res[MSB] != a[MSB]);
            end
            4'b0010: ;  // multiply is handled by the iterative engine
            4'b0011: s_res = a | b;
            4'b0100: s_res = a & b;
            4'b0101: s_res = a ^ b;
            4'b0110: begin
                s_res = a >> shift;
                tmp   = a >> sm1;   // last bit out sits at bit 0 one step early
                s_c   = (shift != '0) && tmp[0];
            end
            4'b0111: begin
                s_res = a << shift;
                tmp   = a << sm1;
                s_c   = (shift != '0) && tmp[MSB];
            end
            4'b1000: begin
                s_res = (a >> shift) | (a << wms);
                s_c   = (shift != '0) && s_res[MSB];
            end
            4'b1010: begin
                s_res = (a << shift) | (a >> wms);
                s_c   = (shift != '0) && s_res[0];
            end
            4'b1011: begin
                s_res = a_s >>> shift;
                tmp   = a_s >>> sm1;
                s_c   = (shift != '0) && tmp[0];
            end
            default: s_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (optcode == 4'b0010) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                            state  <= MUL;
                        end else begin
                            result  <= s_res;
                            illegal <= s_ill;
                            // An undefined optcode leaves the flag set untouched.
                            if (!s_ill) begin
                                negative <= s_res[MSB];
                                zero     <= (s_res == '0);
                                overflow <= s_v;
                                carry    <= s_c;
                            end
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (&cnt) begin
                        result    <= acc_nxt[WIDTH-1:0];
                        negative  <= acc_nxt[MSB];
                        zero      <= (acc_nxt[WIDTH-1:0] == '0);
                        overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
                        carry     <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 32).
//   Directed vectors, back-pressure, illegal opcode, reset mid-multiply and
//   randomized ops checked against a bit-serial behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  optcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry;
    logic        illegal;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .optcode(optcode), .a(a), .b(b), .shift(shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry(carry), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        n, z, v, c, ill;
    } exp_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] pflags = 4'b0000;   // {n,z,v,c} of the last completed op

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: plain arithmetic for add/sub/mul, one-bit-at-a-time
    // loops for shifts and rotates.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] sh, input logic [3:0] pf);
        exp_t e;
        longint sx, sy;
        logic [63:0] p;
        logic [31:0] r;
        logic c, v, ill;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; p = '0;
        case (op)
            4'd0: begin
                p = {32'b0, x} + {32'b0, y};
                r = p[31:0]; c = p[32];
                v = (sx + sy > MAXS) || (sx + sy < MINS);
            end
            4'd1, 4'd9: begin
                r = x - y; c = (x >= y);
                v = (sx - sy > MAXS) || (sx - sy < MINS);
            end
            4'd2: begin
                p = {32'b0, x} * {32'b0, y};
                r = p[31:0]; v = (p[63:32] != 0);
            end
            4'd3: r = x | y;
            4'd4: r = x & y;
            4'd5: r = x ^ y;
            4'd6: begin r = x; for (int i = 0; i < int'(sh); i++) begin c = r[0];  r = r >> 1; end end
            4'd7: begin r = x; for (int i = 0; i < int'(sh); i++) begin c = r[31]; r = r << 1; end end
            4'd8: begin r = x; for (int i = 0; i < int'(sh); i++) begin c = r[0];  r = {r[0], r[31:1]}; end end
            4'd10: begin r = x; for (int i = 0; i < int'(sh); i++) begin c = r[31]; r = {r[30:0], r[31]}; end end
            4'd11: begin r = x; for (int i = 0; i < int'(sh); i++) begin c = r[0];  r = {r[31], r[31:1]}; end end
            default: ill = 1'b1;
        endcase
        e.ill = ill;
        if (ill) begin
            e.res = '0;
            {e.n, e.z, e.v, e.c} = pf;
        end else begin
            e.res = r;
            e.n = r[31]; e.z = (r == 0); e.v = v; e.c = c;
        end
        return e;
    endfunction

    // Issue one op at a negedge, measure latency, check outputs, apply
    // back-pressure for bp cycles, then release.
    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] sh, input int bp,
                          output logic [31:0] gr, output logic [3:0] gf, output logic gi);
        exp_t e;
        int   k;
        int   lat;
        logic bad;
        e = model(op, x, y, sh, pflags);
        k = 0;
        while (!in_ready && k < 50) begin @(negedge clk); k++; end
        chk("in_ready before issue", in_ready, 1);
        in_valid = 1'b1; optcode = op; a = x; b = y; shift = sh;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; shift = 5'($urandom); optcode = 4'($urandom);
        lat = 1; bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk($sformatf("latency op%0d", op), lat, (op == 4'd2) ? 33 : 1);
        chk($sformatf("in_ready busy op%0d", op), bad, 0);
        chk($sformatf("result op%0d a=%0h b=%0h s=%0d", op, x, y, sh), result, e.res);
        chk($sformatf("flags nzvc op%0d a=%0h b=%0h s=%0d", op, x, y, sh),
            {negative, zero, overflow, carry}, {e.n, e.z, e.v, e.c});
        chk($sformatf("illegal op%0d", op), illegal, e.ill);
        gr = result; gf = {negative, zero, overflow, carry}; gi = illegal;
        bad = 1'b0;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;   // must be ignored while busy
            optcode = 4'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            if (!out_valid || in_ready || result !== gr ||
                {negative, zero, overflow, carry} !== gf || illegal !== gi) bad = 1'b1;
        end
        in_valid = 1'b0;
        if (bp > 0) chk($sformatf("hold under back-pressure op%0d", op), bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release out_valid", out_valid, 0);
        chk("release in_ready", in_ready, 1);
        pflags = {e.n, e.z, e.v, e.c};
    endtask

    logic [31:0] r;
    logic [3:0]  f;
    logic        il;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        optcode = '0; a = '0; b = '0; shift = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset flags", {negative, zero, overflow, carry, illegal}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0, r, f, il);
        chk("add ff res", r, 32'hFFFFFFFE); chk("add ff flags", f, 4'b1001);
        run_op(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 0, r, f, il);
        chk("add ovf res", r, 32'h80000000); chk("add ovf flags", f, 4'b1010);
        run_op(4'd1, 32'd1, 32'd5, 5'd0, 0, r, f, il);
        chk("sub res", r, 32'hFFFFFFFC); chk("sub flags", f, 4'b1000);
        run_op(4'd9, 32'd10, 32'd11, 5'd0, 0, r, f, il);
        chk("cmp lt flags", f, 4'b1000);
        run_op(4'd6, 32'd3, 32'd0, 5'd2, 0, r, f, il);
        chk("shr res", r, 32'h0); chk("shr flags", f, 4'b0101);
        run_op(4'd7, 32'h40000000, 32'd0, 5'd2, 0, r, f, il);
        chk("shl res", r, 32'h0); chk("shl flags", f, 4'b0101);
        run_op(4'd8, 32'h1F, 32'd0, 5'd5, 0, r, f, il);
        chk("ror res", r, 32'hF8000000); chk("ror flags", f, 4'b1001);
        run_op(4'd10, 32'h80000001, 32'd0, 5'd1, 0, r, f, il);
        chk("rol res", r, 32'h3); chk("rol flags", f, 4'b0001);
        run_op(4'd11, 32'h80000000, 32'd0, 5'd4, 0, r, f, il);
        chk("asr res", r, 32'hF8000000); chk("asr flags", f, 4'b1000);
        run_op(4'd7, 32'h12345678, 32'd0, 5'd0, 0, r, f, il);
        chk("shl0 res", r, 32'h12345678); chk("shl0 flags", f, 4'b0000);
        run_op(4'd8, 32'h80000001, 32'd0, 5'd0, 0, r, f, il);
        chk("ror0 res", r, 32'h80000001); chk("ror0 flags", f, 4'b1000);
        run_op(4'd2, 32'd5, 32'd2, 5'd0, 10, r, f, il);
        chk("mul res", r, 32'd10); chk("mul flags", f, 4'b0000);
        run_op(4'd2, 32'h10000, 32'h10000, 5'd0, 0, r, f, il);
        chk("mul ovf res", r, 32'h0); chk("mul ovf flags", f, 4'b0110);
        run_op(4'd9, 32'd11, 32'd11, 5'd0, 0, r, f, il);
        chk("cmp eq flags", f, 4'b0101);
        run_op(4'd13, 32'hDEADBEEF, 32'h1234, 5'd3, 2, r, f, il);
        chk("illegal res", r, 32'h0); chk("illegal flag", il, 1);
        chk("illegal keeps flags", f, 4'b0101);

        // Asynchronous reset in the middle of a multiply.
        in_valid = 1'b1; optcode = 4'd2; a = 32'hFFFF; b = 32'hFFFF; shift = '0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst mid-mul out_valid", out_valid, 0);
        chk("rst mid-mul in_ready", in_ready, 1);
        chk("rst mid-mul result", result, 0);
        chk("rst mid-mul flags", {negative, zero, overflow, carry, illegal}, 0);
        pflags = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd13, 32'h1, 32'h2, 5'd0, 0, r, f, il);
        chk("illegal after reset flags", f, 4'b0000);

        // Randomized ops, biased toward corner operand values.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] x, y;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd2 && $urandom_range(0, 2) != 0) op = 4'd0;  // keep mul count modest
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'hFFFFFFFF;
                1: y = 32'h80000000;
                2: y = x;
                3: x = 32'h7FFFFFFF;
                default: ;
            endcase
            run_op(op, x, y, 5'($urandom), $urandom_range(0, 3), r, f, il);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU. Accepts one operation per transaction over a valid/ready input port, computes single-cycle ops in one clock and multiplication with an iterative shift-add engine. It presents the result and a registered N/Z/V/C flag set on a valid/ready output port. It sits between the decode stage and writeback, and can stall both.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), width of the shift/rotate amount
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept an operation
- optcode  input  4  operation select, sampled on accept
- a  input  WIDTH  operand A, sampled on accept
- b  input  WIDTH  operand B, sampled on accept
- shift  input  SHW  shift/rotate amount, sampled on accept
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  registered result
- negative, zero, overflow, carry  output  1 each  registered flags
- illegal  output  1  completed op had an undefined optcode

## Operation
- Opcodes: 0000 add; 0001 sub (a−b); 0010 mul (unsigned, low WIDTH bits); 0011 or; 0100 and; 0101 xor; 0110 logical shift right; 0111 shift left; 1000 rotate right; 1001 cmp; 1010 rotate left; 1011 arithmetic shift right; 1100–1111 illegal.
- Flags are computed from the produced result:
  - n = result[WIDTH−1]; z = (result == 0).
  - add: c = carry-out; v = signed overflow.
  - sub/cmp: c = 1 iff a ≥ b unsigned (no borrow); v = signed overflow.
  - cmp: result = a−b and flags as sub. Consumers ignore the result.
  - mul: v = 1 iff the upper WIDTH product bits are nonzero; c = 0.
  - Logic ops: v = 0, c = 0.
  - Shifts: c = last bit shifted out; c = 0 when shift = 0, and result = a; v = 0.
  - Rotates: c = result[WIDTH−1] (ror) or result[0] (rol), and 0 when shift = 0; v = 0.
- Illegal opcode: result = 0; n, z, v, c keep their previous values; illegal = 1. The op still completes with single-cycle latency.
- FSM:
  - IDLE: in_ready = 1. On in_valid, latch the operands. Go to MUL if optcode = 0010, otherwise compute and go to DONE.
  - MUL: the multiplier iterates one bit of b per cycle for WIDTH cycles, using a 2·WIDTH accumulator and shifting a left / b right. After the last iteration, write the result and flags and go to DONE.
  - DONE: out_valid = 1. result, flags and illegal are held stable. On out_ready go to IDLE.
- result, flags and illegal update only when entering DONE. They hold their values in IDLE and MUL.

## Timing
- Reset (asynchronous): state = IDLE; in_ready = 1; out_valid = 0; result = 0; n = z = v = c = 0; illegal = 0; multiplier state cleared.
- Single-cycle op accepted at edge k: out_valid = 1 after edge k+1.
- mul accepted at edge k: out_valid = 1 after edge k+WIDTH+1.
- in_ready is 0 in MUL and DONE, so there is one op in flight at most.
- Maximum throughput is one op per 2 cycles when out_ready is held high.
- in_valid with in_ready = 0 has no effect. Operands may change freely after accept.
- out_valid stays high with all outputs stable until out_ready is sampled high. Back-pressure of any length is legal.
- Reset asserted mid-MUL or in DONE aborts the op immediately. Nothing is emitted and the flags return to 0.
- in_ready is a function of state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Single-cycle ops, WIDTH=32, out_ready=1:
  - add 0xFFFFFFFF + 0xFFFFFFFF → result 0xFFFFFFFE, n=1, c=1, v=0, out_valid one cycle after accept.
  - add 0x7FFFFFFF + 1 → 0x80000000, v=1, n=1.
- sub 1−5 → 0xFFFFFFFC, n=1, c=0. cmp 11,11 → z=1, c=1. cmp 10,11 → n=1, c=0.
- Shifts/rotates:
  - shr 3 by 2 → 0, c=1, z=1.
  - shl 0x40000000 by 2 → 0, c=1.
  - ror 0x1F by 5 → 0xF8000000, c=1.
  - rol 0x80000001 by 1 → 0x00000003, c=1.
  - asr 0x80000000 by 4 → 0xF8000000.
  - shift=0 → result = a, c=0.
- mul:
  - 5×2 → 10, v=0, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
  - 0x10000×0x10000 → 0, v=1, z=1.
- Back-pressure: hold out_ready=0 for 10 cycles after completion → result/flags stable, in_ready=0, in_valid ignored. Release → next op accepted the following cycle.
- Illegal opcode 1101 after a cmp that set z=1 → result 0, illegal=1, z still 1. Async reset asserted mid-MUL → out_valid=0, flags 0, in_ready=1 immediately.
